imu_sample_reader: RTL

- Producer side of the sensor-fusion sample interface.
- Polls the IMU over SPI at a fixed rate and reads three channels: accel axis 1, accel axis 2, and gyro rate.
- Presents the three values as 10-bit words (Accel1, Accel2, Gyro) and raises a DataReady pulse. The fusion block updates its angle on the rising edge of that pulse.
- Sits between the IMU SPI pins and the fusion block.

---
 rtl/imu_sample_reader.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/imu_sample_reader.sv
// Polls an IMU over SPI (mode 3) at a fixed rate, reads accel1/accel2/gyro
// and publishes all three 10-bit samples atomically with a DataReady pulse.
module imu_sample_reader #(
    parameter int         CLK_DIV       = 4,
    parameter int         SAMPLE_PERIOD = 50000,
    parameter int         DR_WIDTH      = 4,
    parameter logic [6:0] ACCEL1_ADDR   = 7'h32,
    parameter logic [6:0] ACCEL2_ADDR   = 7'h36,
    parameter logic [6:0] GYRO_ADDR     = 7'h1D
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       spi_sclk,
    output logic       spi_cs_n,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic [9:0] Accel1,
    output logic [9:0] Accel2,
    output logic [9:0] Gyro,
    output logic       DataReady,
    output logic       busy,
    output logic       overrun
);

    localparam int TW   = $clog2(SAMPLE_PERIOD + 1);
    localparam int CMAX = (CLK_DIV > DR_WIDTH) ? CLK_DIV : DR_WIDTH;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, PUBLISH} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    bit_q, bit_d;
    logic [1:0]    ch_q, ch_d;
    logic [23:0]   tx_q, tx_d;
    logic [15:0]   rx_q, rx_d;
    logic [9:0]    shd_a1_q, shd_a1_d, shd_a2_q, shd_a2_d, shd_g_q, shd_g_d;
    logic [9:0]    a1_q, a1_d, a2_q, a2_d, g_q, g_d;
    logic          dr_q, dr_d, busy_q, busy_d, ovr_q, ovr_d;
    logic          sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;
    logic          tick, div_last;

    function automatic logic [23:0] frame(input logic [1:0] ch);
        case (ch)
            2'd0:    frame = {1'b1, ACCEL1_ADDR, 16'h0000};
            2'd1:    frame = {1'b1, ACCEL2_ADDR, 16'h0000};
            default: frame = {1'b1, GYRO_ADDR, 16'h0000};
        endcase
    endfunction

    assign tick     = enable && (timer_q == '0);
    assign div_last = (cnt_q == CW'(CLK_DIV - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        ch_d     = ch_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        shd_a1_d = shd_a1_q;
        shd_a2_d = shd_a2_q;
        shd_g_d  = shd_g_q;
        a1_d     = a1_q;
        a2_d     = a2_q;
        g_d      = g_q;
        dr_d     = dr_q;
        sclk_d   = sclk_q;
        cs_n_d   = cs_n_q;
        mosi_d   = mosi_q;
        ovr_d    = ovr_q;
        timer_d  = '0;

        if (enable)
            timer_d = (timer_q == TW'(SAMPLE_PERIOD - 1)) ? '0 : timer_q + 1'b1;
        // Ticks are never queued: a tick while busy only flags the overrun.
        if (tick && busy_q)
            ovr_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = CS_SETUP;
                    ch_d    = 2'd0;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    tx_d    = frame(2'd0);
                end
            end
            CS_SETUP: begin
                if (div_last) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sclk_d  = 1'b0;
                    mosi_d  = tx_q[23];
                    tx_d    = {tx_q[22:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (div_last) begin
                    cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising SCLK: the slave's bit has been stable for a half-period.
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[14:0], spi_miso};
                    end else if (bit_q == 5'd23) begin
                        state_d = CS_HOLD;
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        case (ch_q)
                            2'd0:    shd_a1_d = rx_q[15:6];
                            2'd1:    shd_a2_d = rx_q[15:6];
                            default: shd_g_d  = rx_q[15:6];
                        endcase
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b0;
                        mosi_d = tx_q[23];
                        tx_d   = {tx_q[22:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CS_HOLD: begin
                if (div_last) begin
                    cnt_d = '0;
                    if (ch_q == 2'd2) begin
                        state_d = PUBLISH;
                        a1_d    = shd_a1_q;
                        a2_d    = shd_a2_q;
                        g_d     = shd_g_q;
                        dr_d    = 1'b1;
                    end else begin
                        state_d = CS_SETUP;
                        ch_d    = ch_q + 2'd1;
                        cs_n_d  = 1'b0;
                        tx_d    = frame(ch_q + 2'd1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PUBLISH: begin
                if (cnt_q == CW'(DR_WIDTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    dr_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            cnt_q    <= '0;
            bit_q    <= '0;
            ch_q     <= '0;
            tx_q     <= '0;
            rx_q     <= '0;
            shd_a1_q <= '0;
            shd_a2_q <= '0;
            shd_g_q  <= '0;
            a1_q     <= '0;
            a2_q     <= '0;
            g_q      <= '0;
            dr_q     <= 1'b0;
            busy_q   <= 1'b0;
            ovr_q    <= 1'b0;
            sclk_q   <= 1'b1;
            cs_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            ch_q     <= ch_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            shd_a1_q <= shd_a1_d;
            shd_a2_q <= shd_a2_d;
            shd_g_q  <= shd_g_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            g_q      <= g_d;
            dr_q     <= dr_d;
            busy_q   <= busy_d;
            ovr_q    <= ovr_d;
            sclk_q   <= sclk_d;
            cs_n_q   <= cs_n_d;
            mosi_q   <= mosi_d;
        end
    end

    assign spi_sclk  = sclk_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_mosi  = mosi_q;
    assign Accel1    = a1_q;
    assign Accel2    = a2_q;
    assign Gyro      = g_q;
    assign DataReady = dr_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule
